spi_rr_arbiter: RTL and testbench

//   Shares one SPI master port (SCLK/MOSI/MISO/SS_n, mode 0, MSB first) between NREQ on-chip requesters.

---
 rtl/spi_rr_arbiter_pkg.sv | 29 ++
 rtl/spi_shift_engine.sv | 94 +++++++++
 rtl/spi_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_rr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rr_arbiter_pkg.sv
// rtl/spi_rr_arbiter_pkg.sv - shared types, SPI mode constants and width helper for the SPI round-robin arbiter
package spi_rr_arbiter_pkg;

    // Top-level arbitration state: XFER covers the engine's SETUP/SHIFT/HOLD phases
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER,
        ARB_GAP,
        ARB_RELOAD
    } arb_state_t;

    // Shift engine timing phases
    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_SETUP,
        ENG_SHIFT,
        ENG_HOLD
    } eng_state_t;

    // SPI mode 0: clock idles low, data sampled on the rising edge
    localparam logic SCLK_IDLE   = 1'b0;
    localparam logic SS_INACTIVE = 1'b1;

    // Counter width that never collapses to zero bits when n <= 1
    function automatic int cwidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SETUP/SHIFT/HOLD timing and mode-0 MSB-first bit shifting for one byte
module spi_shift_engine
    import spi_rr_arbiter_pkg::*;
#(
    parameter int DW      = 8,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] tx_byte,
    input  logic          miso,
    output logic          sclk,
    output logic          mosi,
    output logic          finish,
    output logic [DW-1:0] rx_byte
);

    localparam int HW = cwidth(CLK_DIV);
    localparam int BW = cwidth(2 * DW + 1);
    localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] EDGE_LOAD = BW'(2 * DW);

    eng_state_t    state;
    logic [HW-1:0] half_cnt;
    logic [BW-1:0] edge_cnt;
    logic [DW-1:0] tx_sr;
    logic [DW-1:0] rx_sr;

    // finish marks the last HOLD cycle; the owner of the frame acts on it at the closing edge
    assign finish  = (state == ENG_HOLD) && (half_cnt == '0);
    assign rx_byte = rx_sr;

    // Phase sequencing, sclk generation and the tx/rx shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENG_IDLE;
            half_cnt <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sclk     <= SCLK_IDLE;
            mosi     <= 1'b0;
        end else begin
            case (state)
                ENG_IDLE: begin
                    if (start) begin
                        tx_sr    <= tx_byte;
                        mosi     <= tx_byte[DW-1];
                        half_cnt <= HALF_LOAD;
                        state    <= ENG_SETUP;
                    end
                end
                ENG_SETUP: begin
                    if (half_cnt == '0) begin
                        half_cnt <= HALF_LOAD;
                        edge_cnt <= EDGE_LOAD;
                        state    <= ENG_SHIFT;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                ENG_SHIFT: begin
                    if (half_cnt == '0) begin
                        half_cnt <= HALF_LOAD;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt - 1'b1;
                        if (!sclk) begin
                            rx_sr <= {rx_sr[DW-2:0], miso};
                        end else begin
                            tx_sr <= {tx_sr[DW-2:0], 1'b0};
                            mosi  <= tx_sr[DW-2];
                        end
                        if (edge_cnt == BW'(1)) begin
                            state <= ENG_HOLD;
                        end
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                ENG_HOLD: begin
                    if (half_cnt == '0) begin
                        mosi  <= 1'b0;
                        state <= ENG_IDLE;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                default: state <= ENG_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - round-robin sharing of one SPI mode-0 master port; SPI_ARB_LOCK_EN enables multi-byte lock
module spi_rr_arbiter
    import spi_rr_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = 8,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*DW-1:0] tx_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rx_data,
    output logic               busy,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               ss_n
);

    localparam int PW = cwidth(NREQ);
    localparam int GW = cwidth(CLK_DIV);
    localparam logic [GW-1:0] GAP_LOAD = GW'(CLK_DIV - 1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;
    logic [PW-1:0] sel;
    logic [GW-1:0] gap_cnt;
    logic [DW-1:0] eng_tx;
    logic [DW-1:0] eng_rx;
    logic          eng_start;
    logic          eng_finish;
    logic          any_req;
    logic          lock_hit;

    assign any_req = |req;
    assign busy    = (state != ARB_IDLE);

`ifdef SPI_ARB_LOCK_EN
    // The current owner keeps the port while it asserts both lock and req
    assign lock_hit = |(lock & req & gnt);
`else
    // Every byte is its own frame; lock has no effect in this build
    assign lock_hit = 1'b0 & (|lock);
`endif

    // Winner: first requester after the pointer; scanning downwards lets the nearest one overwrite
    always_comb begin
        win_idx = ptr;
        cand    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    // Byte source: new winner when leaving IDLE, current owner when reloading a locked byte
    always_comb begin
        sel       = (state == ARB_IDLE) ? win_idx : cur;
        eng_start = ((state == ARB_IDLE) && any_req) || (state == ARB_RELOAD);
        eng_tx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == PW'(i)) begin
                eng_tx = tx_data[i*DW +: DW];
            end
        end
    end

    spi_shift_engine #(
        .DW      (DW),
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (eng_start),
        .tx_byte (eng_tx),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .finish  (eng_finish),
        .rx_byte (eng_rx)
    );

    // Frame FSM: grant, chip select, done/rx_data capture and deselect gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            ptr     <= PW'(NREQ - 1);
            cur     <= '0;
            gnt     <= '0;
            done    <= '0;
            rx_data <= '0;
            ss_n    <= SS_INACTIVE;
            gap_cnt <= '0;
        end else begin
            done <= '0;
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        gnt   <= NREQ'(1) << win_idx;
                        cur   <= win_idx;
                        ptr   <= win_idx;
                        ss_n  <= ~SS_INACTIVE;
                        state <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    if (eng_finish) begin
                        rx_data <= eng_rx;
                        done    <= gnt;
                        if (lock_hit) begin
                            state <= ARB_RELOAD;
                        end else begin
                            gnt     <= '0;
                            ss_n    <= SS_INACTIVE;
                            gap_cnt <= GAP_LOAD;
                            state   <= ARB_GAP;
                        end
                    end
                end
                ARB_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ARB_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ARB_RELOAD: begin
                    state <= ARB_XFER;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// tb/tb_spi_rr_arbiter.sv - randomized self-checking bench with a frame-level SPI slave and RR model
`timescale 1ns/100ps
module tb_spi_rr_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int C    = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*DW-1:0] tx_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rx_data;
    logic               busy;
    logic               sclk;
    logic               mosi;
    logic               miso;
    logic               ss_n;

    logic [DW-1:0] tx_b [NREQ];
    logic          loop_en;
    logic          miso_reg;

    int checks = 0;
    int errors = 0;

    spi_rr_arbiter #(.NREQ(NREQ), .DW(DW), .CLK_DIV(C)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .lock    (lock),
        .tx_data (tx_data),
        .gnt     (gnt),
        .done    (done),
        .rx_data (rx_data),
        .busy    (busy),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .ss_n    (ss_n)
    );

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : miso_reg;

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < NREQ; i++) tx_data[i*DW +: DW] = tx_b[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Slave-side observer: records mosi at rising sclk, shifts out slave_byte on falling sclk
    logic          prev_sclk = 1'b0;
    logic          prev_ss   = 1'b1;
    logic          mosi_bits[$];
    int            rise_total  = 0;
    int            ss_rise_cnt = 0;
    int            ss_hi       = 1000;
    logic          mosi_seen1  = 1'b0;
    logic [DW-1:0] slave_byte  = '0;
    int            slave_idx   = 0;

    always @(negedge clk) begin
        if (sclk && !prev_sclk) begin
            mosi_bits.push_back(mosi);
            rise_total++;
            if (ss_n) check("sclk_with_ss_high", ss_n, 0);
        end
        if (!sclk && prev_sclk) begin
            slave_idx++;
            if (slave_idx < DW) miso_reg = slave_byte[DW-1-slave_idx];
        end
        if (!ss_n && mosi) mosi_seen1 = 1'b1;
        if (!ss_n && prev_ss) check("ss_gap_min", 32'(ss_hi >= C), 1);
        if (ss_n && !prev_ss) ss_rise_cnt++;
        ss_hi     = ss_n ? ss_hi + 1 : 0;
        prev_sclk = sclk;
        prev_ss   = ss_n;
    end

    // Round-robin reference: pointer is the last winner, search starts just after it
    int model_ptr = NREQ - 1;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic slave_load(input logic [DW-1:0] b);
        slave_byte = b;
        slave_idx  = 0;
        miso_reg   = b[DW-1];
    endtask

    task automatic wait_done(output logic [NREQ-1:0] dv, output int cyc, output logic [NREQ-1:0] gs);
        cyc = 0;
        dv  = '0;
        gs  = '0;
        while (dv == '0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (gs == '0) gs = gnt;
            dv = done;
        end
        if (dv == '0) check("done_timeout", 0, 1);
    endtask

    task automatic frame(input string nm, input int w, input logic [DW-1:0] exp_rx,
                         input bit chk_lat, output logic [NREQ-1:0] dv);
        logic [NREQ-1:0] gs;
        int              cyc;
        logic [DW-1:0]   mb;
        wait_done(dv, cyc, gs);
        check({nm, "_done"}, 32'(dv), 32'(1) << w);
        check({nm, "_gnt"}, 32'(gs), 32'(1) << w);
        if (chk_lat) check({nm, "_latency"}, cyc, 1 + C + 2 * DW * C + C);
        check({nm, "_rx"}, 32'(rx_data), 32'(exp_rx));
        check({nm, "_nbits"}, mosi_bits.size(), DW);
        mb = '0;
        foreach (mosi_bits[k]) mb = {mb[DW-2:0], mosi_bits[k]};
        check({nm, "_mosi"}, 32'(mb), 32'(tx_b[w]));
        mosi_bits.delete();
        model_ptr = w;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] dv;
        logic [DW-1:0]   sb;
        int              w;
        int              r0;
        int              n;

        rst_n    = 1'b0;
        req      = '0;
        lock     = '0;
        loop_en  = 1'b0;
        miso_reg = 1'b0;
        for (int i = 0; i < NREQ; i++) tx_b[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rx", 32'(rx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_ss_n", 32'(ss_n), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Solo frame, loopback: latency and byte integrity
        loop_en = 1'b1;
        tx_b[0] = 8'hA5;
        mosi_bits.delete();
        req = 2'b01;
        w = rr_pick(req, model_ptr);
        frame("solo", w, 8'hA5, 1'b1, dv);
        req = '0;
        @(negedge clk);
        check("done_pulse_width", 32'(done), 0);
        wait_idle("solo");

        // Both held: strict alternation
        loop_en = 1'b0;
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NREQ; i++) tx_b[i] = DW'($urandom);
            sb = DW'($urandom);
            slave_load(sb);
            w = rr_pick(req, model_ptr);
            frame($sformatf("alt%0d", f), w, sb, 1'b0, dv);
        end

        // Random request patterns; winner drops its request after done
        for (int f = 0; f < 16; f++) begin
            req = (req & ~dv) | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (req == '0) req = NREQ'(1) << $urandom_range(0, NREQ - 1);
            for (int i = 0; i < NREQ; i++) tx_b[i] = DW'($urandom);
            sb = DW'($urandom);
            slave_load(sb);
            w = rr_pick(req, model_ptr);
            frame($sformatf("rnd%0d", f), w, sb, 1'b0, dv);
        end
        req = '0;
        wait_idle("rnd");

        // Request withdrawn mid-SHIFT: frame still completes
        sb = DW'($urandom);
        slave_load(sb);
        tx_b[1] = DW'($urandom);
        r0 = rise_total;
        req = 2'b10;
        w = rr_pick(req, model_ptr);
        n = 0;
        while (rise_total - r0 < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req = '0;
        frame("drop", w, sb, 1'b0, dv);
        wait_idle("drop");
        repeat (20) @(negedge clk);
        check("drop_stays_idle", 32'({busy, gnt}), 0);

        // miso stuck high, all-zero tx
        slave_load(8'hFF);
        tx_b[0] = 8'h00;
        tx_b[1] = 8'h00;
        mosi_seen1 = 1'b0;
        req = 2'b01;
        w = rr_pick(req, model_ptr);
        frame("zeros", w, 8'hFF, 1'b0, dv);
        check("zeros_mosi_low", 32'(mosi_seen1), 0);
        req = '0;
        wait_idle("zeros");

        // Asynchronous reset in the middle of SHIFT
        slave_load(DW'($urandom));
        r0 = rise_total;
        req = 2'b10;
        n = 0;
        while (rise_total - r0 < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #0.5;
        check("arst_ss_n", 32'(ss_n), 1);
        check("arst_sclk", 32'(sclk), 0);
        check("arst_gnt", 32'(gnt), 0);
        #0.5;
        rst_n     = 1'b1;
        model_ptr = NREQ - 1;
        ss_hi     = 1000;
        prev_sclk = 1'b0;
        prev_ss   = 1'b1;
        mosi_bits.delete();
        tx_b[0] = DW'($urandom);
        tx_b[1] = DW'($urandom);
        sb = DW'($urandom);
        slave_load(sb);
        req = 2'b11;
        w = rr_pick(req, model_ptr);
        frame("post_rst", w, sb, 1'b1, dv);
        req = '0;
        wait_idle("post_rst");

`ifdef SPI_ARB_LOCK_EN
        // Locked three-byte burst under one chip select
        r0 = rise_total;
        n  = ss_rise_cnt;
        tx_b[0] = 8'h11;
        sb = DW'($urandom);
        slave_load(sb);
        lock = 2'b01;
        req  = 2'b01;
        w = rr_pick(req, model_ptr);
        frame("lock1", w, sb, 1'b0, dv);
        check("lock1_ss_low", 32'(ss_n), 0);
        check("lock1_gnt_kept", 32'(gnt), 1);
        tx_b[0] = 8'h22;
        sb = DW'($urandom);
        slave_load(sb);
        frame("lock2", 0, sb, 1'b0, dv);
        check("lock2_ss_low", 32'(ss_n), 0);
        check("lock2_gnt_kept", 32'(gnt), 1);
        lock = '0;
        tx_b[0] = 8'h33;
        sb = DW'($urandom);
        slave_load(sb);
        frame("lock3", 0, sb, 1'b0, dv);
        req = '0;
        wait_idle("lock");
        check("lock_sclk_pulses", rise_total - r0, 3 * DW);
        check("lock_ss_frames", ss_rise_cnt - n, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
